// File: rtl/hazard_ctrl_scoreboard.sv
// Hazard control for the 5-stage MIPS pipeline, sitting beside the ID stage.
// Tracks in-flight register writers in a shift-register scoreboard, selects
// forwarding sources per operand, stalls on load-use, and sequences a
// multi-cycle flush with a registered PC redirect on taken branches.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   issue_valid_i                ID holds a valid instruction
//   rs_addr_i/rs_used_i          Rs source and read-enable
//   rt_addr_i/rt_used_i          Rt source and read-enable
//   dest_addr_i/dest_we_i        destination register and write-enable
//   is_load_i                    ID instruction is a load
//   branch_taken_i               branch resolved taken this cycle
//   target_branch_address_i      resolved branch target
//   stall_o, bubble_o, flush_o   IF/ID hold, ID/EX NOP inject, IF/ID kill
//   redirect_valid_o/addr_o      one-cycle PC load strobe and value
//   fwd_rs_o, fwd_rt_o           0 = register file, k+1 = scoreboard entry k
//   stall_cnt_o                  saturating stall-cycle counter
module hazard_ctrl_scoreboard #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FWD_STAGES   = 3,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned FW          = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic              rs_used_i,
  input  logic              rt_used_i,
  input  logic [REG_AW-1:0] dest_addr_i,
  input  logic              dest_we_i,
  input  logic              is_load_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       target_branch_address_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_addr_o,
  output logic [FW-1:0]     fwd_rs_o,
  output logic [FW-1:0]     fwd_rt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned FCW = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } sb_entry_t;

  state_e           state_q, state_d;
  logic [FCW-1:0]   cnt_q, cnt_d;
  sb_entry_t        sb_q [FWD_STAGES];
  sb_entry_t        sb_in_d;
  logic             redirect_valid_q;
  logic [31:0]      redirect_addr_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             in_flush;
  logic             rs_lu, rt_lu;
  logic [FW-1:0]    rs_sel, rt_sel;
  logic             stall_c, bubble_c;

  // Youngest-match search: walk oldest to youngest so the lowest index wins.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    rs_lu  = 1'b0;
    rt_lu  = 1'b0;
    for (int k = int'(FWD_STAGES) - 1; k >= 0; k--) begin
      if (rs_used_i && (rs_addr_i != '0) && sb_q[k].valid && (sb_q[k].dest == rs_addr_i)) begin
        rs_sel = FW'(k + 1);
        rs_lu  = sb_q[k].is_load && (k < int'(LOAD_LAT));
      end
      if (rt_used_i && (rt_addr_i != '0) && sb_q[k].valid && (sb_q[k].dest == rt_addr_i)) begin
        rt_sel = FW'(k + 1);
        rt_lu  = sb_q[k].is_load && (k < int'(LOAD_LAT));
      end
    end
  end

  // Stall/bubble/forward decode; flush and a same-cycle branch override load-use.
  always_comb begin
    in_flush = (state_q == FLUSH);
    stall_c  = !in_flush && (rs_lu || rt_lu) && !branch_taken_i;
    bubble_c = stall_c || in_flush;
    sb_in_d  = '0;
    if (issue_valid_i && dest_we_i && (dest_addr_i != '0) && !bubble_c) begin
      sb_in_d.valid   = 1'b1;
      sb_in_d.dest    = dest_addr_i;
      sb_in_d.is_load = is_load_i;
    end
  end

  // FSM next state; a branch in either state (re)loads the flush counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken_i) begin
      state_d = FLUSH;
      cnt_d   = FCW'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      if (cnt_q == '0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - FCW'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard shift, redirect capture and stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(FWD_STAGES); k++) begin
        sb_q[k] <= '0;
      end
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      stall_cnt_q      <= '0;
    end else begin
      for (int k = 1; k < int'(FWD_STAGES); k++) begin
        sb_q[k] <= sb_q[k-1];
      end
      sb_q[0]          <= sb_in_d;
      redirect_valid_q <= branch_taken_i;
      if (branch_taken_i) begin
        redirect_addr_q <= target_branch_address_i;
      end
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_o          = stall_c;
  assign bubble_o         = bubble_c;
  assign flush_o          = in_flush;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign fwd_rs_o         = (in_flush || rs_lu) ? '0 : rs_sel;
  assign fwd_rt_o         = (in_flush || rt_lu) ? '0 : rt_sel;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_scoreboard.sv
// Bench for hazard_ctrl_scoreboard: two instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=2/CNT_W=8) share one stimulus stream and are checked every cycle
// against a behavioural model of the pipeline hazard rules.
module tb_hazard_ctrl_scoreboard;

  localparam int NI = 2;
  localparam int FS = 3;
  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, issue_valid, rs_used, rt_used, dest_we, is_load, branch;
  logic [4:0]  rs_addr, rt_addr, dest_addr;
  logic [31:0] target;

  logic        stall0, bubble0, flush0, rv0;
  logic [31:0] ra0;
  logic [1:0]  frs0, frt0;
  logic [15:0] sc0;
  logic        stall1, bubble1, flush1, rv1;
  logic [31:0] ra1;
  logic [1:0]  frs1, frt1;
  logic [7:0]  sc1;

  int total = 0;
  int bad   = 0;

  hazard_ctrl_scoreboard #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(1), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .dest_addr_i(dest_addr), .dest_we_i(dest_we), .is_load_i(is_load),
    .branch_taken_i(branch), .target_branch_address_i(target),
    .stall_o(stall0), .bubble_o(bubble0), .flush_o(flush0),
    .redirect_valid_o(rv0), .redirect_addr_o(ra0),
    .fwd_rs_o(frs0), .fwd_rt_o(frt0), .stall_cnt_o(sc0));

  hazard_ctrl_scoreboard #(.REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .FLUSH_CYCLES(2), .CNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .dest_addr_i(dest_addr), .dest_we_i(dest_we), .is_load_i(is_load),
    .branch_taken_i(branch), .target_branch_address_i(target),
    .stall_o(stall1), .bubble_o(bubble1), .flush_o(flush1),
    .redirect_valid_o(rv1), .redirect_addr_o(ra1),
    .fwd_rs_o(frs1), .fwd_rt_o(frt1), .stall_cnt_o(sc1));

  // Reference model state: in-flight writers listed youngest first.
  bit          mv  [NI][FS];
  int          md  [NI][FS];
  bit          ml  [NI][FS];
  int          mfl [NI];
  bit          mrv [NI];
  logic [31:0] mra [NI];
  int          msc [NI];

  function automatic int ll_of(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int cmax_of(int i);
    return (i == 0) ? 65535 : 255;
  endfunction

  function automatic int youngest(int i, bit used, logic [4:0] a);
    if (!used || a == 5'd0) return -1;
    for (int k = 0; k < FS; k++)
      if (mv[i][k] && md[i][k] == int'(a)) return k;
    return -1;
  endfunction

  task automatic model_comb(input int i, output bit st, output bit bu, output bit fl,
                            output int frs, output int frt);
    int ks, kt;
    bit lus, lut;
    fl  = mfl[i] > 0;
    ks  = youngest(i, rs_used, rs_addr);
    kt  = youngest(i, rt_used, rt_addr);
    lus = 0;
    lut = 0;
    if (ks >= 0) lus = ml[i][ks] && (ks < ll_of(i));
    if (kt >= 0) lut = ml[i][kt] && (kt < ll_of(i));
    frs = (fl || ks < 0 || lus) ? 0 : ks + 1;
    frt = (fl || kt < 0 || lut) ? 0 : kt + 1;
    st  = !fl && (lus || lut) && !branch;
    bu  = st || fl;
  endtask

  task automatic model_edge();
    bit st, bu, fl;
    int frs, frt;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int k = 0; k < FS; k++) begin
          mv[i][k] = 0; md[i][k] = 0; ml[i][k] = 0;
        end
        mfl[i] = 0; mrv[i] = 0; mra[i] = 32'd0; msc[i] = 0;
      end else begin
        model_comb(i, st, bu, fl, frs, frt);
        if (st && msc[i] < cmax_of(i)) msc[i]++;
        for (int k = FS - 1; k > 0; k--) begin
          mv[i][k] = mv[i][k-1]; md[i][k] = md[i][k-1]; ml[i][k] = ml[i][k-1];
        end
        mv[i][0] = issue_valid && dest_we && dest_addr != 5'd0 && !bu;
        md[i][0] = int'(dest_addr);
        ml[i][0] = is_load;
        if (branch) mfl[i] = FC;
        else if (mfl[i] > 0) mfl[i]--;
        mrv[i] = branch;
        if (branch) mra[i] = target;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit st, bu, fl;
    int frs, frt;
    for (int i = 0; i < NI; i++) begin
      model_comb(i, st, bu, fl, frs, frt);
      if (i == 0) begin
        check("d0 stall", 32'(stall0), 32'(st));
        check("d0 bubble", 32'(bubble0), 32'(bu));
        check("d0 flush", 32'(flush0), 32'(fl));
        check("d0 fwd_rs", 32'(frs0), 32'(frs));
        check("d0 fwd_rt", 32'(frt0), 32'(frt));
        check("d0 rvalid", 32'(rv0), 32'(mrv[0]));
        check("d0 raddr", ra0, mra[0]);
        check("d0 scnt", 32'(sc0), 32'(msc[0]));
      end else begin
        check("d1 stall", 32'(stall1), 32'(st));
        check("d1 bubble", 32'(bubble1), 32'(bu));
        check("d1 flush", 32'(flush1), 32'(fl));
        check("d1 fwd_rs", 32'(frs1), 32'(frs));
        check("d1 fwd_rt", 32'(frt1), 32'(frt));
        check("d1 rvalid", 32'(rv1), 32'(mrv[1]));
        check("d1 raddr", ra1, mra[1]);
        check("d1 scnt", 32'(sc1), 32'(msc[1]));
      end
    end
  endtask

  task automatic drv(input bit iv, input logic [4:0] rs, input bit rsu, input logic [4:0] rt,
                     input bit rtu, input logic [4:0] d, input bit we, input bit ld,
                     input bit br, input logic [31:0] tgt);
    issue_valid = iv; rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
    dest_addr = d; dest_we = we; is_load = ld; branch = br; target = tgt;
  endtask

  task automatic idle();
    drv(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 32'd0);
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (5) begin settle(); tick(); end
    settle();
    check("rst fwd_rs", 32'(frs0), 32'd0);
    check("rst scnt", 32'(sc0), 32'd0);

    // add r3 = r1 + r2, then read r3 on both operands as it ages.
    drv(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 32'd0); settle(); tick();
    drv(1, 5'd3, 1, 5'd3, 1, 5'd0, 0, 0, 0, 32'd0); settle();
    check("exe fwd_rs", 32'(frs0), 32'd1);
    check("exe fwd_rt", 32'(frt0), 32'd1);
    tick(); settle();
    check("ma fwd_rs", 32'(frs0), 32'd2);
    tick(); settle();
    check("wb fwd_rt", 32'(frt0), 32'd3);
    tick();

    // lw r5 followed by a reader of r5.
    drv(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 32'd0); settle(); tick();
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 32'd0); settle();
    check("lu0 stall", 32'(stall0), 32'd1);
    check("lu1 stall", 32'(stall1), 32'd1);
    tick(); settle();
    check("lu0 release", 32'(stall0), 32'd0);
    check("lu0 fwd", 32'(frs0), 32'd2);
    check("lu1 stall2", 32'(stall1), 32'd1);
    tick(); settle();
    check("lu1 fwd", 32'(frs1), 32'd3);
    check("lu0 scnt", 32'(sc0), 32'd1);
    check("lu1 scnt", 32'(sc1), 32'd2);
    tick();
    idle(); repeat (4) begin settle(); tick(); end

    // Two writers of r4: youngest wins. Then r0 is never tracked.
    drv(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 32'd0); settle(); tick();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 32'd0); settle(); tick();
    drv(1, 5'd0, 0, 5'd4, 1, 5'd0, 0, 0, 0, 32'd0); settle();
    check("youngest fwd_rt", 32'(frt0), 32'd1);
    tick();
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 32'd0); settle(); tick();
    drv(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 32'd0); settle();
    check("r0 fwd_rs", 32'(frs0), 32'd0);
    check("r0 stall", 32'(stall0), 32'd0);
    tick();
    idle(); repeat (3) begin settle(); tick(); end

    // Taken branch with a pending load-use in the same cycle.
    drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 32'd0); settle(); tick();
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 1, 32'h0000_0040); settle();
    check("br no stall", 32'(stall0), 32'd0);
    tick(); idle(); settle();
    check("br rvalid", 32'(rv0), 32'd1);
    check("br raddr", ra0, 32'h0000_0040);
    check("br flush1", 32'(flush0), 32'd1);
    tick(); settle();
    check("br rvalid drop", 32'(rv0), 32'd0);
    check("br flush2", 32'(flush0), 32'd1);
    tick(); settle();
    check("br flush end", 32'(flush0), 32'd0);
    tick();

    // Reset during the first flush cycle aborts it.
    drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 1, 32'h0000_0080); settle(); tick();
    idle(); rst = 1'b1; settle(); tick();
    rst = 1'b0; settle();
    check("rst flush", 32'(flush0), 32'd0);
    check("rst rvalid", 32'(rv0), 32'd0);
    check("rst scnt2", 32'(sc0), 32'd0);
    tick();

    // Back-to-back dependent loads drive the narrow counter into saturation.
    drv(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 32'd0);
    repeat (420) begin settle(); tick(); end
    settle();
    check("sat scnt", 32'(sc1), 32'hFF);
    tick();
    idle(); repeat (4) begin settle(); tick(); end

    // Randomized traffic over a small register window.
    repeat (3000) begin
      drv(1'($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 11) == 0),
          $urandom());
      rst = ($urandom_range(0, 149) == 0);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_scoreboard.md
Name: hazard_ctrl_scoreboard

Overview:
- Parametrised successor to the single-stage hazard detector for the 5-stage MIPS pipeline.
- Tracks in-flight register writers across FWD_STAGES downstream stages (EXE, MA, WB, ...) in a shift-register scoreboard.
- Generates per-operand forwarding selects and load-use stalls for a configurable load latency.
- Sequences a multi-cycle branch flush with a registered redirect.
- Sits beside the ID stage and drives the IF/ID hold, the ID/EXE bubble and the PC redirect.

Parameters:
- REG_AW, 5: register address width; register 0 is hardwired zero and is never tracked.
- FWD_STAGES, 3: number of tracked stages after ID (entry 0 = EXE, 1 = MA, 2 = WB); range 1..7.
- LOAD_LAT, 1: first scoreboard index at which load data is forwardable; range 0..FWD_STAGES-1.
- FLUSH_CYCLES, 2: cycles flush_o stays asserted per taken branch; range 1..15.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  ID holds a valid instruction.
- rs_addr_i  in  REG_AW  source Rs of the ID instruction.
- rt_addr_i  in  REG_AW  source Rt of the ID instruction.
- rs_used_i  in  1  ID instruction reads Rs.
- rt_used_i  in  1  ID instruction reads Rt (0 for immediate forms, shift-by-immediate reads Rt only).
- dest_addr_i  in  REG_AW  destination (Rd for R-type, Rt for I-type/load).
- dest_we_i  in  1  ID instruction writes the register file.
- is_load_i  in  1  ID instruction is a load.
- branch_taken_i  in  1  branch resolved taken this cycle.
- target_branch_address_i  in  32  resolved target.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  inject NOP into ID/EX.
- flush_o  out  1  kill IF/ID contents.
- redirect_valid_o  out  1  one-cycle PC load strobe.
- redirect_addr_o  out  32  PC load value.
- fwd_rs_o  out  FW  Rs select: 0 = register file, k+1 = scoreboard entry k; FW = clog2(FWD_STAGES+1).
- fwd_rt_o  out  FW  Rt select, same encoding as fwd_rs_o.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_i=1 at an edge):
  - scoreboard all invalid;
  - FSM enters RUN with flush counter 0;
  - redirect_valid_o=0, redirect_addr_o=0, stall_cnt_o=0.
- Consequence of reset: stall_o, bubble_o, flush_o = 0 and fwd_rs_o = fwd_rt_o = 0 from the first cycle after reset.
- Reset during FLUSH aborts the flush with no redirect.
- Scoreboard entry: {valid, dest, is_load}. Every edge, entry k+1 <= entry k and the oldest entry is discarded.
- Entry 0 load value:
  - {1, dest_addr_i, is_load_i} when issue_valid_i & dest_we_i & dest_addr_i != 0 & !bubble_o & !flush_o;
  - otherwise invalid.
- Source match: for Rs, used & addr != 0 & entry valid & entry.dest == addr; same rule for Rt.
- Forwarding (combinational from registered scoreboard and current inputs):
  - the youngest matching entry (lowest k) wins;
  - fwd = k+1 when that entry is a non-load, or a load with k >= LOAD_LAT;
  - fwd = 0 when there is no match.
- Load-use hazard: the youngest matching entry for either operand is a load with k < LOAD_LAT.
  - Then stall_o = bubble_o = 1 and fwd for that operand = 0.
  - The stall repeats each cycle until the load shifts to index LOAD_LAT, giving LOAD_LAT - k stall cycles.
  - Combinational; no added latency.
- FSM states:
  - RUN: stall/forward logic active. branch_taken_i=1 -> FLUSH with cnt = FLUSH_CYCLES-1; at the same edge redirect_valid_o <= 1 and redirect_addr_o <= target_branch_address_i.
  - FLUSH: flush_o=1, bubble_o=1, stall_o=0, no scoreboard insert. cnt==0 -> RUN, else cnt decrements.
  - branch_taken_i in FLUSH restarts the flush (cnt reloads, new redirect captured). Last branch wins.
- redirect_valid_o is a single-cycle pulse registered one cycle after branch_taken_i.
- redirect_addr_o holds its value until the next capture.
- Priority: flush over load-use stall. A stall is never asserted while flush_o=1.
- Branch and load-use in the same RUN cycle: the stall is suppressed and the transition to FLUSH occurs.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at all-ones without wrapping.
- Instructions reading register 0 never stall or forward.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0; fwd_rs_o = fwd_rt_o = 0; stall_cnt_o = 0.
- Issue add r3=r1+r2, next cycle rs=r3, rt=r3 -> fwd_rs_o = fwd_rt_o = 1, no stall. One cycle later (r3 at MA) -> 2. A further cycle later -> 3.
- lw r5 (LOAD_LAT=1), next ID uses rs=r5 -> stall_o = bubble_o = 1 for exactly 1 cycle, then fwd_rs_o = 2. stall_cnt_o = 1. With LOAD_LAT=2 -> 2 stall cycles, then fwd = 3.
- Writers to r4 at entries 0 and 1, ID reads rt=r4 -> fwd_rt_o = 1 (youngest wins). Writer to r0, ID reads r0 -> fwd = 0, no stall.
- branch_taken_i with target 0x0000_0040, FLUSH_CYCLES=2 -> redirect_valid_o pulses with addr 0x40 next cycle; flush_o = 1 for 2 cycles. A load-use pending in that cycle does not stall.
- Assert rst_i during the first FLUSH cycle -> flush_o = 0 and scoreboard empty next cycle; stall_cnt_o = 0. Force 2^16+3 stall cycles -> stall_cnt_o = 0xFFFF.
